// File: rtl/td4_uart_loader.sv
// td4_uart_loader: receives 8N1 UART bytes on one pin and turns each byte
// into a TD4 program-memory write (opcode = bits [3:0], immediate = bits
// [7:4]), filling addresses 0..15 in order.
//
// Optional feature macro: TD4_LOADER_CHECKSUM_EN
//   When defined, one extra byte is received after address 15 is written.
//   checksum_ok reports whether it equals the XOR of the 16 program bytes.
//   When undefined, the CHECK state does not exist and checksum_ok is 0.
//
// Handshake: there is no back-pressure. mem_write is a one-cycle strobe, and
// mem_address/opcode/immediate are valid in the cycle it is high and hold
// their values until the next strobe.
//
// Debug: the FSM register is the signal "state" (type state_t); bind
// checkers to it directly.

module td4_uart_loader #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       load_en,
  output logic [3:0] mem_address,
  output logic [3:0] opcode,
  output logic [3:0] immediate,
  output logic       mem_write,
  output logic       busy,
  output logic       done,
  output logic       frame_err,
  output logic       checksum_ok
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    START      = 3'd2,
    DATA       = 3'd3,
    STOP       = 3'd4,
    WRITE      = 3'd5,
`ifdef TD4_LOADER_CHECKSUM_EN
    CHECK      = 3'd6,
`endif
    DONE       = 3'd7
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [3:0]      addr;
  // Start detection needs the line to be seen high first, so a line that is
  // still low after a framing error cannot be mistaken for a new start bit.
  logic            armed;

`ifdef TD4_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
  logic            check_phase;
`else
  assign checksum_ok = 1'b0;
`endif

  // Two-flop synchronizer for the asynchronous rx pin, idle-high at reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Session FSM: UART framing, byte assembly, write strobe and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      addr        <= '0;
      armed       <= 1'b0;
      mem_address <= '0;
      opcode      <= '0;
      immediate   <= '0;
      mem_write   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_err   <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
      csum        <= '0;
      check_phase <= 1'b0;
      checksum_ok <= 1'b0;
`endif
    end else begin
      mem_write <= 1'b0;
      if (!load_en) begin
        // Abort: done is only ever 1 in DONE (or IDLE after DONE), so
        // leaving it untouched keeps it exactly when the session completed.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          // Level-sensitive accept: IDLE is only re-entered with load_en
          // low, so a high level here is a fresh session request.
          IDLE: begin
            state     <= WAIT_START;
            busy      <= 1'b1;
            done      <= 1'b0;
            frame_err <= 1'b0;
            addr      <= '0;
            armed     <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
            csum        <= '0;
            check_phase <= 1'b0;
            checksum_ok <= 1'b0;
`endif
          end

          WAIT_START: begin
            if (!armed) begin
              if (rx_s) armed <= 1'b1;
            end else if (!rx_s) begin
              state <= START;
              timer <= '0;
            end
          end

          // Re-check the line at mid start bit to reject short glitches.
          START: begin
            if (timer == HALF_LAST) begin
              timer <= '0;
              if (rx_s) begin
                state <= WAIT_START;
              end else begin
                state   <= DATA;
                bit_idx <= '0;
              end
            end else begin
              timer <= timer + TIMER_ONE;
            end
          end

          // LSB first: each sample enters at the top and shifts down.
          DATA: begin
            if (timer == FULL_LAST) begin
              timer <= '0;
              shreg <= {rx_s, shreg[7:1]};
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 3'd1;
            end else begin
              timer <= timer + TIMER_ONE;
            end
          end

          STOP: begin
            if (timer == FULL_LAST) begin
              timer <= '0;
              if (!rx_s) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
`ifdef TD4_LOADER_CHECKSUM_EN
                if (check_phase) begin
                  checksum_ok <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= DONE;
                end else
`endif
                state <= WAIT_START;
              end
`ifdef TD4_LOADER_CHECKSUM_EN
              else if (check_phase) begin
                state <= CHECK;
              end
`endif
              else begin
                state       <= WRITE;
                mem_write   <= 1'b1;
                mem_address <= addr;
                opcode      <= shreg[3:0];
                immediate   <= shreg[7:4];
              end
            end else begin
              timer <= timer + TIMER_ONE;
            end
          end

          // Strobe cycle; the address counter stops at 15 so it never wraps.
          WRITE: begin
`ifdef TD4_LOADER_CHECKSUM_EN
            csum <= csum ^ {immediate, opcode};
`endif
            if (addr == 4'd15) begin
`ifdef TD4_LOADER_CHECKSUM_EN
              check_phase <= 1'b1;
              state       <= WAIT_START;
`else
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
`endif
            end else begin
              addr  <= addr + 4'd1;
              state <= WAIT_START;
            end
          end

`ifdef TD4_LOADER_CHECKSUM_EN
          // Compare the received checksum byte with the running XOR.
          CHECK: begin
            checksum_ok <= (shreg == csum);
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
`endif

          // Session complete; line traffic is ignored until load_en drops.
          DONE: begin
            state <= DONE;
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_td4_uart_loader.sv
// Directed bench for td4_uart_loader with CLKS_PER_BIT = 8.
// Honours TD4_LOADER_CHECKSUM_EN the same way as the design.

module tb_td4_uart_loader;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       load_en;
  logic [3:0] mem_address;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic       mem_write;
  logic       busy;
  logic       done;
  logic       frame_err;
  logic       checksum_ok;

  int vectors;
  int miscompares;
  int n_wr;
  int exp_wr;
  logic [11:0] exp_q[$];

  td4_uart_loader #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .load_en     (load_en),
    .mem_address (mem_address),
    .opcode      (opcode),
    .immediate   (immediate),
    .mem_write   (mem_write),
    .busy        (busy),
    .done        (done),
    .frame_err   (frame_err),
    .checksum_ok (checksum_ok)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected write entry: {address, immediate, opcode}
  task automatic push_exp(input logic [3:0] a, input logic [7:0] b);
    exp_q.push_back({a, b[7:4], b[3:0]});
    exp_wr++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic new_session();
    load_en = 1'b0;
    idle(2);
    load_en = 1'b1;
    idle(3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_op"},   32'(opcode),      32'd0);
    check({tag, "_imm"},  32'(immediate),   32'd0);
    check({tag, "_wr"},   32'(mem_write),   32'd0);
    check({tag, "_busy"}, 32'(busy),        32'd0);
    check({tag, "_done"}, 32'(done),        32'd0);
    check({tag, "_ferr"}, 32'(frame_err),   32'd0);
    check({tag, "_csok"}, 32'(checksum_ok), 32'd0);
  endtask

  // Scoreboard: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) check("spurious_wr", 32'(mem_write), 32'd0);
      else check("wr_entry", 32'({mem_address, immediate, opcode}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [7:0] b;
    logic [7:0] x;
    vectors = 0; miscompares = 0; n_wr = 0; exp_wr = 0;
    rx = 1'b1; load_en = 1'b0; rst_n = 1'b0;
    idle(4);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // 1: sixteen back-to-back bytes k*0x11
    load_en = 1'b1;
    idle(3);
    check("busy_after_accept", 32'(busy), 32'd1);
    for (int k = 0; k < 16; k++) begin
      b = 8'(k * 8'h11);
      push_exp(4'(k), b);
      send_byte(b, 1'b1);
    end
`ifdef TD4_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    idle(3);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_ferr", 32'(frame_err), 32'd0);
    check("t1_pending", 32'(exp_q.size()), 32'd0);
`ifdef TD4_LOADER_CHECKSUM_EN
    check("t1_csok", 32'(checksum_ok), 32'd1);
`endif
    // traffic in DONE is ignored
    send_byte(8'hEE, 1'b1);
    idle(3);
    check("done_ignore_addr", 32'(mem_address), 32'd15);
    check("done_ignore_done", 32'(done), 32'd1);

    // 2: abort keeps done from DONE, new session clears it
    load_en = 1'b0;
    idle(2);
    check("abort_done_kept", 32'(done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    load_en = 1'b1;
    idle(3);
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);

    // 3: framing error at position 2, then good byte lands at address 2
    push_exp(4'd0, 8'h21); send_byte(8'h21, 1'b1);
    push_exp(4'd1, 8'h43); send_byte(8'h43, 1'b1);
    send_byte(8'hB3, 1'b0);
    idle(CPB);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_addr_hold", 32'(mem_address), 32'd1);
    push_exp(4'd2, 8'h5A); send_byte(8'h5A, 1'b1);
    idle(2);
    check("after_ferr_addr", 32'(mem_address), 32'd2);
    check("after_ferr_op", 32'(opcode), 32'hA);
    check("after_ferr_imm", 32'(immediate), 32'h5);

    // 4: 2-cycle glitch in WAIT_START is rejected
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(2 * CPB);
    check("glitch_pending", 32'(exp_q.size()), 32'd0);
    check("glitch_wr_count", 32'(n_wr), 32'(exp_wr));
    push_exp(4'd3, 8'h77); send_byte(8'h77, 1'b1);
    push_exp(4'd4, 8'hC8); send_byte(8'hC8, 1'b1);
    idle(2);
    check("glitch_next_addr", 32'(mem_address), 32'd4);

    // 5: abort after 5 bytes, restart and load a full program
    load_en = 1'b0;
    idle(2);
    check("abort5_busy", 32'(busy), 32'd0);
    check("abort5_done", 32'(done), 32'd0);
    load_en = 1'b1;
    idle(3);
    check("restart5_ferr", 32'(frame_err), 32'd0);
    x = 8'h00;
    for (int k = 0; k < 16; k++) begin
      b = {4'(15 - k), 4'(k)};
      x = x ^ b;
      push_exp(4'(k), b);
      send_byte(b, 1'b1);
    end
`ifdef TD4_LOADER_CHECKSUM_EN
    send_byte(x, 1'b1);
`endif
    idle(3);
    check("t5_done", 32'(done), 32'd1);
    check("t5_ferr", 32'(frame_err), 32'd0);
    check("t5_last_op", 32'(opcode), 32'hF);
    check("t5_last_imm", 32'(immediate), 32'h0);

    // 6: reset during DATA of byte 3
    new_session();
    push_exp(4'd0, 8'h3C); send_byte(8'h3C, 1'b1);
    push_exp(4'd1, 8'h5A); send_byte(8'h5A, 1'b1);
    push_exp(4'd2, 8'h96); send_byte(8'h96, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midbyte_rst");
    rx = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(12 * CPB);
    check("rst_pending", 32'(exp_q.size()), 32'd0);
    check("rst_wr_count", 32'(n_wr), 32'(exp_wr));

`ifdef TD4_LOADER_CHECKSUM_EN
    // 7: checksum good then bad
    for (int pass = 0; pass < 2; pass++) begin
      new_session();
      for (int k = 1; k <= 16; k++) begin
        push_exp(4'(k - 1), 8'(k));
        send_byte(8'(k), 1'b1);
      end
      send_byte((pass == 0) ? 8'h10 : 8'h11, 1'b1);
      idle(3);
      check("cs_done", 32'(done), 32'd1);
      check("cs_ok", 32'(checksum_ok), (pass == 0) ? 32'd1 : 32'd0);
    end
`endif

    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("final_wr_count", 32'(n_wr), 32'(exp_wr));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
